line_buffer_ctrl: RTL

Sequencing controller for a bank of four line buffers that turns a raster pixel stream into a 3-row vertical window stream for the preprocessing filters.
- Write side: steers each accepted pixel into the current fill buffer.
- Read side: advances the three buffers holding the active rows in lock-step and presents per-column 3-row windows under valid/ready.
- Tracks rows per frame, applies back-pressure when all four buffers hold unconsumed lines, and signals end of frame.
- Sits between the pixel input stage and the 3x3 kernel datapath; the four line buffers sit beside it and are driven only by it.

---
 rtl/line_buffer_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/line_buffer_ctrl.sv
// Sequencing controller for four line buffers producing a 3-row vertical window stream.
// Optional sticky protocol-error output o_err is enabled by defining LBCTRL_ERR_EN.
module line_buffer_ctrl #(
    parameter int LINE_W = 30,
    parameter int IMG_H  = 30
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_frame_start,
    input  logic                      i_pix_valid,
    output logic                      o_pix_ready,
    output logic                      o_lb_rst,
    output logic [3:0]                o_lb_wr,
    output logic [3:0]                o_lb_rd,
    output logic [1:0]                o_row_sel,
    output logic [$clog2(LINE_W)-1:0] o_col,
    output logic                      o_win_valid,
    input  logic                      i_win_ready,
    output logic                      o_frame_done
`ifdef LBCTRL_ERR_EN
    ,
    output logic                      o_err
`endif
);

    localparam int COL_W = $clog2(LINE_W);
    localparam int ROW_W = $clog2(IMG_H + 1);

    localparam logic [COL_W-1:0] LAST_COL     = COL_W'(LINE_W - 1);
    localparam logic [ROW_W-1:0] ROWS_TOTAL   = ROW_W'(IMG_H);
    localparam logic [ROW_W-1:0] WIN_ROWS     = ROW_W'(IMG_H - 2);
    localparam logic [ROW_W-1:0] LAST_WIN_ROW = ROW_W'(IMG_H - 3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       wr_idx_q,     wr_idx_d;
    logic [COL_W-1:0] wr_col_q,     wr_col_d;
    logic [ROW_W-1:0] rows_wr_q,    rows_wr_d;
    logic [1:0]       row_sel_q,    row_sel_d;
    logic [COL_W-1:0] rd_col_q,     rd_col_d;
    logic [ROW_W-1:0] win_rows_q,   win_rows_d;
    logic [2:0]       rows_valid_q, rows_valid_d;

    logic frame_go;
    logic accept;
    logic handshake;
    logic line_done;
    logic row_done;
    logic last_window;

    assign frame_go    = (state_q == IDLE) && i_frame_start;
    assign accept      = i_pix_valid && o_pix_ready;
    assign handshake   = o_win_valid && i_win_ready;
    assign line_done   = accept && (wr_col_q == LAST_COL);
    assign row_done    = handshake && (rd_col_q == LAST_COL);
    assign last_window = row_done && (win_rows_q == LAST_WIN_ROW);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_frame_start) state_d = ACTIVE;
            ACTIVE:  if (last_window)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_pix_ready  = 1'b0;
        o_win_valid  = 1'b0;
        o_frame_done = 1'b0;
        case (state_q)
            ACTIVE: begin
                o_pix_ready = (rows_wr_q < ROWS_TOTAL) && (rows_valid_q < 3'd4);
                o_win_valid = (rows_valid_q >= 3'd3) && (win_rows_q < WIN_ROWS);
            end
            DONE:    o_frame_done = 1'b1;
            default: ;
        endcase
    end

    // The one buffer not read is the one three slots past the top row.
    assign o_lb_wr   = accept ? (4'b0001 << wr_idx_q) : 4'b0000;
    assign o_lb_rd   = handshake ? ~(4'b0001 << (row_sel_q + 2'd3)) : 4'b0000;
    assign o_lb_rst  = ~i_rst_n | frame_go;
    assign o_row_sel = row_sel_q;
    assign o_col     = rd_col_q;

    always_comb begin
        wr_idx_d     = wr_idx_q;
        wr_col_d     = wr_col_q;
        rows_wr_d    = rows_wr_q;
        row_sel_d    = row_sel_q;
        rd_col_d     = rd_col_q;
        win_rows_d   = win_rows_q;
        rows_valid_d = rows_valid_q;

        if (frame_go) begin
            wr_idx_d     = '0;
            wr_col_d     = '0;
            rows_wr_d    = '0;
            row_sel_d    = '0;
            rd_col_d     = '0;
            win_rows_d   = '0;
            rows_valid_d = '0;
        end else begin
            if (accept) begin
                if (line_done) begin
                    wr_col_d  = '0;
                    wr_idx_d  = wr_idx_q + 2'd1;
                    rows_wr_d = rows_wr_q + ROW_W'(1);
                end else begin
                    wr_col_d  = wr_col_q + COL_W'(1);
                end
            end

            if (handshake) begin
                if (row_done) begin
                    rd_col_d   = '0;
                    row_sel_d  = row_sel_q + 2'd1;
                    win_rows_d = win_rows_q + ROW_W'(1);
                end else begin
                    rd_col_d   = rd_col_q + COL_W'(1);
                end
            end

            // A line landing while a row retires leaves the occupancy unchanged.
            case ({line_done, row_done})
                2'b10:   rows_valid_d = rows_valid_q + 3'd1;
                2'b01:   rows_valid_d = rows_valid_q - 3'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_idx_q     <= '0;
            wr_col_q     <= '0;
            rows_wr_q    <= '0;
            row_sel_q    <= '0;
            rd_col_q     <= '0;
            win_rows_q   <= '0;
            rows_valid_q <= '0;
        end else begin
            wr_idx_q     <= wr_idx_d;
            wr_col_q     <= wr_col_d;
            rows_wr_q    <= rows_wr_d;
            row_sel_q    <= row_sel_d;
            rd_col_q     <= rd_col_d;
            win_rows_q   <= win_rows_d;
            rows_valid_q <= rows_valid_d;
        end
    end

`ifdef LBCTRL_ERR_EN
    logic err_q;
    logic err_event;

    assign err_event = (i_frame_start && (state_q != IDLE)) ||
                       (i_pix_valid && (state_q == IDLE));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (err_event) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`endif

endmodule
